// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer swap controller and its scan address generator.
package fb_pkg;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [1:0] {
        START,
        RENDER,
        WAIT_VS
    } fb_state_t;

    function automatic int frame_pixels(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

endpackage

// File: rtl/fb_scan_addr_gen.sv
// Registered scan-out read address: linear pixel index plus read-ahead, wrapped into one frame.
module fb_scan_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int READ_AHEAD = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] scan_addr
);

    localparam int FRAME = frame_pixels(H_RES, V_RES);
    localparam int LW    = ADDR_W + 2;
    localparam logic signed [LW-1:0] FRAME_S = LW'(FRAME);
    localparam logic [ADDR_W-1:0] BLANK_ADDR =
        (READ_AHEAD < 0) ? ADDR_W'(FRAME + READ_AHEAD) : ADDR_W'(READ_AHEAD);

    logic signed [LW-1:0] lin;
    logic [ADDR_W-1:0]    wrapped;
    logic                 blank;

    // Two spare bits keep the sum signed and let a single add/subtract fold it back into the frame.
    always_comb begin
        lin = $signed(LW'(draw_y) * LW'(H_RES) + LW'(draw_x) + LW'(READ_AHEAD));
        if (lin[LW-1]) begin
            wrapped = ADDR_W'(lin + FRAME_S);
        end else if (lin >= FRAME_S) begin
            wrapped = ADDR_W'(lin - FRAME_S);
        end else begin
            wrapped = ADDR_W'(lin);
        end
        blank = ({1'b0, draw_x} >= 11'(H_RES)) || ({1'b0, draw_y} >= 11'(V_RES));
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scan_addr <= '0;
        end else begin
            scan_addr <= blank ? BLANK_ADDR : wrapped;
        end
    end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double/triple frame-buffer swap controller: vsync edge detect, render hand-off FSM,
// buffer index bookkeeping, dropped-frame counter and scan address generation.
module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int NUM_BUF    = 2,
    parameter int READ_AHEAD = 1,
    parameter int ADDR_W     = 19
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              vsync,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              render_done,
    output logic              render_start,
    output logic [1:0]        render_buf,
    output logic [1:0]        display_buf,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              frame_tick,
    output logic [7:0]        dropped_frames
);

    fb_state_t state, state_nxt;
    logic      vs_s, vs_d;
    buf_idx_t  pending_buf, display_nxt, render_nxt, pending_nxt;
    logic      pending_valid, pending_valid_nxt;
    logic      render_start_nxt, tick_only;
    logic [7:0] dropped_nxt;

    // vsync is asynchronous to Clk, so it passes a capture flop before the edge detect.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_s           <= 1'b0;
            vs_d           <= 1'b0;
            frame_tick     <= 1'b0;
            state          <= START;
            display_buf    <= 2'd0;
            render_buf     <= 2'd1;
            pending_buf    <= 2'd2;
            pending_valid  <= 1'b0;
            render_start   <= 1'b0;
            dropped_frames <= 8'd0;
        end else begin
            vs_s           <= vsync;
            vs_d           <= vs_s;
            frame_tick     <= vs_s & ~vs_d;
            state          <= state_nxt;
            display_buf    <= display_nxt;
            render_buf     <= render_nxt;
            pending_buf    <= pending_nxt;
            pending_valid  <= pending_valid_nxt;
            render_start   <= render_start_nxt;
            dropped_frames <= dropped_nxt;
        end
    end

    // pending_buf always names the third index; pending_valid says whether it holds a finished frame.
    always_comb begin
        state_nxt         = state;
        display_nxt       = display_buf;
        render_nxt        = render_buf;
        pending_nxt       = pending_buf;
        pending_valid_nxt = pending_valid;
        dropped_nxt       = dropped_frames;
        render_start_nxt  = 1'b0;
        tick_only         = 1'b0;

        case (state)
            START: begin
                render_start_nxt = 1'b1;
                state_nxt        = RENDER;
                tick_only        = frame_tick;
            end
            RENDER: begin
                if (render_done && frame_tick) begin
                    display_nxt       = render_buf;
                    render_nxt        = display_buf;
                    pending_valid_nxt = 1'b0;
                    state_nxt         = START;
                end else if (render_done) begin
                    if (NUM_BUF == 3) begin
                        pending_nxt       = render_buf;
                        render_nxt        = pending_buf;
                        pending_valid_nxt = 1'b1;
                        state_nxt         = START;
                    end else begin
                        state_nxt = WAIT_VS;
                    end
                end else begin
                    tick_only = frame_tick;
                end
            end
            WAIT_VS: begin
                if (frame_tick) begin
                    display_nxt = render_buf;
                    render_nxt  = display_buf;
                    state_nxt   = START;
                end
            end
            default: state_nxt = START;
        endcase

        // A vsync edge without a newly completed frame shows the pending frame if any, else counts a drop.
        if (tick_only) begin
            if (NUM_BUF == 3 && pending_valid) begin
                display_nxt       = pending_buf;
                pending_nxt       = display_buf;
                pending_valid_nxt = 1'b0;
            end else if (dropped_frames != 8'hFF) begin
                dropped_nxt = dropped_frames + 8'd1;
            end
        end
    end

    fb_scan_addr_gen #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .READ_AHEAD (READ_AHEAD),
        .ADDR_W     (ADDR_W)
    ) u_scan_addr (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .draw_x    (draw_x),
        .draw_y    (draw_y),
        .scan_addr (scan_addr)
    );

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl: a double-buffered (+1 read-ahead) and a triple-buffered (-1 read-ahead) instance
// share one stimulus stream and are each checked every cycle against an event-level reference model.
module tb_fb_swap_ctrl;

    localparam int FRAME = 640 * 480;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       vsync = 1'b0;
    logic       render_done = 1'b0;
    logic [9:0] draw_x = '0;
    logic [9:0] draw_y = '0;

    logic        rs_a, ft_a, rs_b, ft_b;
    logic [1:0]  rend_a, disp_a, rend_b, disp_b;
    logic [18:0] scan_a, scan_b;
    logic [7:0]  drop_a, drop_b;

    int errors = 0;
    int checks = 0;

    // Model state, index 0 = double buffer, index 1 = triple buffer
    int m_disp[2], m_rend[2], m_newest[2], m_drop[2], m_scan[2];
    bit m_ready[2], m_owe[2], m_rs[2];
    bit m_tick;
    bit vs_hist[2];

    typedef struct {
        int x;
        int y;
        int exp_p1;
        int exp_m1;
    } addr_vec_t;

    addr_vec_t addr_tab[8];

    always #10 Clk = ~Clk;

    fb_swap_ctrl #(.H_RES(640), .V_RES(480), .NUM_BUF(2), .READ_AHEAD(1), .ADDR_W(19)) dut_double (
        .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .draw_x(draw_x), .draw_y(draw_y),
        .render_done(render_done), .render_start(rs_a), .render_buf(rend_a), .display_buf(disp_a),
        .scan_addr(scan_a), .frame_tick(ft_a), .dropped_frames(drop_a)
    );

    fb_swap_ctrl #(.H_RES(640), .V_RES(480), .NUM_BUF(3), .READ_AHEAD(-1), .ADDR_W(19)) dut_triple (
        .Clk(Clk), .Reset_n(Reset_n), .vsync(vsync), .draw_x(draw_x), .draw_y(draw_y),
        .render_done(render_done), .render_start(rs_b), .render_buf(rend_b), .display_buf(disp_b),
        .scan_addr(scan_b), .frame_tick(ft_b), .dropped_frames(drop_b)
    );

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int addr_ref(input int x, input int y, input int ra);
        int v;
        if (x >= 640 || y >= 480) v = ra;
        else v = y * 640 + x + ra;
        return ((v % FRAME) + FRAME) % FRAME;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_disp[k] = 0; m_rend[k] = 1; m_newest[k] = -1; m_drop[k] = 0; m_scan[k] = 0;
            m_ready[k] = 1'b0; m_owe[k] = 1'b1; m_rs[k] = 1'b0;
        end
        m_tick = 1'b0;
        vs_hist[0] = 1'b0;
        vs_hist[1] = 1'b0;
    endtask

    task automatic swap_disp_rend(input int k);
        int t;
        t = m_disp[k]; m_disp[k] = m_rend[k]; m_rend[k] = t;
    endtask

    // vsync edge that arrives without a freshly completed frame
    task automatic no_frame_tick(input int k);
        if (k == 1 && m_newest[k] >= 0) begin
            m_disp[k] = m_newest[k];
            m_newest[k] = -1;
        end else if (m_drop[k] < 255) begin
            m_drop[k]++;
        end
    endtask

    task automatic model_edge(input bit done, input bit vs, input int x, input int y);
        bit tick, new_tick;
        int freed;
        tick = m_tick;
        new_tick = vs_hist[0] & ~vs_hist[1];
        vs_hist[1] = vs_hist[0];
        vs_hist[0] = vs;
        for (int k = 0; k < 2; k++) begin
            m_rs[k] = m_owe[k];
            if (m_owe[k]) begin
                m_owe[k] = 1'b0;
                if (tick) no_frame_tick(k);
            end else if (k == 0) begin
                if (m_ready[k]) begin
                    if (tick) begin swap_disp_rend(k); m_ready[k] = 1'b0; m_owe[k] = 1'b1; end
                end else if (done) begin
                    if (tick) begin swap_disp_rend(k); m_owe[k] = 1'b1; end
                    else m_ready[k] = 1'b1;
                end else if (tick) begin
                    no_frame_tick(k);
                end
            end else begin
                if (done && tick) begin
                    swap_disp_rend(k); m_newest[k] = -1; m_owe[k] = 1'b1;
                end else if (done) begin
                    freed = (m_newest[k] >= 0) ? m_newest[k] : 3 - m_disp[k] - m_rend[k];
                    m_newest[k] = m_rend[k];
                    m_rend[k] = freed;
                    m_owe[k] = 1'b1;
                end else if (tick) begin
                    no_frame_tick(k);
                end
            end
        end
        m_tick = new_tick;
        m_scan[0] = addr_ref(x, y, 1);
        m_scan[1] = addr_ref(x, y, -1);
    endtask

    task automatic compare_all();
        check_output("double.render_start", int'(rs_a), int'(m_rs[0]));
        check_output("double.render_buf", int'(rend_a), m_rend[0]);
        check_output("double.display_buf", int'(disp_a), m_disp[0]);
        check_output("double.frame_tick", int'(ft_a), int'(m_tick));
        check_output("double.dropped", int'(drop_a), m_drop[0]);
        check_output("double.scan_addr", int'(scan_a), m_scan[0]);
        check_output("triple.render_start", int'(rs_b), int'(m_rs[1]));
        check_output("triple.render_buf", int'(rend_b), m_rend[1]);
        check_output("triple.display_buf", int'(disp_b), m_disp[1]);
        check_output("triple.frame_tick", int'(ft_b), int'(m_tick));
        check_output("triple.dropped", int'(drop_b), m_drop[1]);
        check_output("triple.scan_addr", int'(scan_b), m_scan[1]);
    endtask

    // One clock: inputs seen before the edge drive the model, outputs are compared 1 ns after it
    task automatic step();
        bit d, v, r;
        int x, y;
        d = render_done; v = vsync; r = Reset_n;
        x = int'(draw_x); y = int'(draw_y);
        @(posedge Clk);
        if (!r) model_reset();
        else model_edge(d, v, x, y);
        #1;
        compare_all();
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        int vs_count;

        addr_tab[0] = '{639, 479, 0, 307198};
        addr_tab[1] = '{0, 0, 1, 307199};
        addr_tab[2] = '{700, 10, 1, 307199};
        addr_tab[3] = '{0, 480, 1, 307199};
        addr_tab[4] = '{5, 2, 1286, 1284};
        addr_tab[5] = '{639, 0, 640, 638};
        addr_tab[6] = '{1023, 1023, 1, 307199};
        addr_tab[7] = '{0, 479, 306561, 306559};

        model_reset();
        Reset_n = 1'b0;
        step();
        step();
        check_output("reset.render_start", int'(rs_a), 0);
        check_output("reset.display_buf", int'(disp_a), 0);
        check_output("reset.render_buf", int'(rend_a), 1);
        check_output("reset.dropped", int'(drop_a), 0);
        check_output("reset.scan_addr", int'(scan_a), 0);

        Reset_n = 1'b1;
        step();
        check_output("release.render_start_double", int'(rs_a), 1);
        check_output("release.render_start_triple", int'(rs_b), 1);
        step();
        check_output("release.render_start_pulse", int'(rs_a), 0);
        repeat (3) step();

        // Double buffer: completed frame waits for the next vsync edge
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        repeat (3) step();
        vsync = 1'b1;
        step();
        check_output("vsync.tick_not_yet", int'(ft_a), 0);
        step();
        check_output("vsync.tick_2cyc", int'(ft_a), 1);
        step();
        vsync = 1'b0;
        check_output("swap.display_buf", int'(disp_a), 1);
        check_output("swap.render_buf", int'(rend_a), 0);
        step();
        check_output("swap.render_start", int'(rs_a), 1);
        repeat (4) step();

        repeat (3) vsync_pulse();
        check_output("drop3.dropped", int'(drop_a), 3);
        check_output("drop3.display_buf", int'(disp_a), 1);

        // render_done lands in the frame_tick cycle
        vsync = 1'b1;
        step();
        step();
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        vsync = 1'b0;
        check_output("same_cycle.display_buf", int'(disp_a), 0);
        check_output("same_cycle.render_buf", int'(rend_a), 1);
        check_output("same_cycle.dropped", int'(drop_a), 3);
        step();
        check_output("same_cycle.render_start", int'(rs_a), 1);
        repeat (4) step();

        repeat (300) begin
            vsync = 1'b1;
            step();
            vsync = 1'b0;
            step();
        end
        repeat (3) step();
        check_output("saturate.dropped", int'(drop_a), 255);

        // Triple buffer: two frames finish before a vsync, the newer one is shown
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        check_output("triple.first_start", int'(rs_b), 1);
        repeat (2) step();
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        check_output("triple.handoff1_render_buf", int'(rend_b), 2);
        step();
        check_output("triple.handoff1_start", int'(rs_b), 1);
        step();
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        check_output("triple.handoff2_render_buf", int'(rend_b), 1);
        step();
        check_output("triple.handoff2_start", int'(rs_b), 1);
        vsync = 1'b1;
        repeat (3) step();
        vsync = 1'b0;
        check_output("triple.newest_display", int'(disp_b), 2);
        check_output("triple.render_keeps", int'(rend_b), 1);
        check_output("triple.distinct", (disp_b != rend_b) ? 1 : 0, 1);
        repeat (4) step();

        // Reset while a finished frame waits for vsync in the double buffer
        render_done = 1'b1;
        step();
        render_done = 1'b0;
        step();
        vsync = 1'b1;
        step();
        Reset_n = 1'b0;
        step();
        check_output("wait_rst.display_buf", int'(disp_a), 0);
        check_output("wait_rst.render_buf", int'(rend_a), 1);
        check_output("wait_rst.frame_tick", int'(ft_a), 0);
        vsync = 1'b0;
        step();
        Reset_n = 1'b1;
        step();
        check_output("wait_rst.restart", int'(rs_a), 1);
        repeat (6) step();
        check_output("wait_rst.no_swap", int'(disp_a), 0);

        for (int i = 0; i < 8; i++) begin
            draw_x = 10'(addr_tab[i].x);
            draw_y = 10'(addr_tab[i].y);
            step();
            check_output("addr_tab.plus1", int'(scan_a), addr_tab[i].exp_p1);
            check_output("addr_tab.minus1", int'(scan_b), addr_tab[i].exp_m1);
        end

        vs_count = 10;
        for (int i = 0; i < 3000; i++) begin
            render_done = ($urandom_range(0, 7) == 0);
            draw_x = 10'($urandom_range(0, 720));
            draw_y = 10'($urandom_range(0, 500));
            if ($urandom_range(0, 3) == 0) draw_x = ($urandom_range(0, 1) == 0) ? 10'd639 : 10'd0;
            if (vs_count == 0) begin
                vsync = ~vsync;
                vs_count = vsync ? 3 : int'($urandom_range(2, 40));
            end else begin
                vs_count--;
            end
            Reset_n = ($urandom_range(0, 999) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
